keypad_debounce: RTL and testbench

- Upstream stage of the microwave time-entry/control block.
- Takes raw, bouncing, asynchronous pushbutton levels for digits 0-9.
- Produces clean single-cycle one-hot key strokes on the 10-bit keypad bus that feeds time entry, plus a binary key code and a valid strobe.
- Enforces one-key-at-a-time entry and a lockout while cooking.

---
 rtl/microwave_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_debounce.sv | 139 +++++++++++++
 tb/tb_keypad_debounce.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg : shared types and helpers for the microwave control blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package microwave_pkg;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } KEYPAD_STATE_T;

  function automatic logic [3:0] onehot_to_bin(input logic [NUM_KEYS-1:0] oh);
    logic [3:0] bin;
    bin = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) bin = 4'(i);
    end
    return bin;
  endfunction

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  function automatic logic is_multihot(input logic [NUM_KEYS-1:0] v);
    return (v & (v - NUM_KEYS'(1))) != '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : parameterized-width two-flop synchronizer, cleared by rst
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ---------------------------------------------------------------------------
// keypad_debounce : debounces digit buttons into one-hot single-cycle strokes
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_debounce
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys_raw,
  input  logic       lock,
  output logic [9:0] keypad,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       multi_err
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync;

  sync_2ff #(.WIDTH(NUM_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (keys_raw),
    .q   (sync)
  );

  KEYPAD_STATE_T       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] cap_q, cap_d;
  logic [NUM_KEYS-1:0] keypad_q, keypad_d;
  logic                key_valid_q, key_valid_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                stroke;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      keypad_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      keypad_q    <= keypad_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    keypad_d    = '0;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    stroke      = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_onehot(sync)) begin
          cap_d   = sync;
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (sync != cap_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          stroke  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (sync == '0) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (sync == cap_q) begin
          if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            stroke = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
`endif
      end
      RELEASE_WAIT: begin
        // Any activity during release re-arms HELD, so no stroke can slip through.
        if (sync != '0) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // key_code tracks every accept; lock only suppresses the visible stroke.
    if (stroke) begin
      key_code_d = onehot_to_bin(cap_q);
      if (!lock) begin
        keypad_d    = cap_q;
        key_valid_d = 1'b1;
      end
    end
  end

  assign keypad    = keypad_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign multi_err = is_multihot(sync);

endmodule

`default_nettype wire

// File: tb/tb_keypad_debounce.sv
// ---------------------------------------------------------------------------
// tb_keypad_debounce : randomized scoreboard bench with a behavioural keypad model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_keypad_debounce;

  localparam int D = 4;
  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keys_raw;
  logic       lock;
  logic [9:0] keypad;
  logic       key_valid;
  logic [3:0] key_code;
  logic       multi_err;

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_raw  (keys_raw),
    .lock      (lock),
    .keypad    (keypad),
    .key_valid (key_valid),
    .key_code  (key_code),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] kp;
  } stroke_t;

  stroke_t    exp_q[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] exp_code = 4'd0;
  logic       exp_multi = 1'b0;

  // Behavioural model: sync is raw delayed by two samples; a stroke is due
  // when a single key stays put through a full debounce window while armed,
  // and arming returns only after D+1 consecutive all-released samples.
  initial begin : model
    logic [9:0] h0, h1, s;
    bit  armed, held;
    int  cand, run, zrun, rc, capk;
    h0 = '0; h1 = '0;
    armed = 1; cand = -1; run = 0; zrun = 0; rc = 0; capk = 0;
    forever begin
      @(posedge clk);
      cyc++;
      s = h1;
      if (rst) begin
        armed = 1; cand = -1; run = 0; zrun = 0; rc = 0; capk = 0;
        exp_code = 4'd0;
      end else if (armed) begin
        if (cand < 0) begin
          if ($countones(s) == 1) begin
            for (int i = 0; i < 10; i++) if (s[i]) cand = i;
            run = 0;
          end
        end else if (s != (10'b1 << cand)) begin
          cand = -1;
        end else if (run == D - 1) begin
          exp_code = 4'(cand);
          if (!lock) exp_q.push_back('{cyc, 10'b1 << cand});
          capk = cand; cand = -1; armed = 0; zrun = 0; rc = 0;
        end else begin
          run++;
        end
      end else begin
        held = (zrun == 0);
        if (s == '0) begin
          zrun++;
          rc = 0;
          if (zrun == D + 1) armed = 1;
        end else begin
          zrun = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (held && s == (10'b1 << capk)) begin
            if (rc == R - 1) begin
              exp_code = 4'(capk);
              if (!lock) exp_q.push_back('{cyc, 10'b1 << capk});
              rc = 0;
            end else begin
              rc++;
            end
          end else begin
            rc = 0;
          end
`else
          if (held) rc = 0;
`endif
        end
      end
      if (rst) begin
        h1 = '0; h0 = '0;
      end else begin
        h1 = h0; h0 = keys_raw;
      end
      exp_multi = ($countones(h1) >= 2);
    end
  end

  initial begin : monitor
    stroke_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      compared++;
      if (multi_err !== exp_multi) begin
        mismatched++;
        $display("FAIL multi_err cyc=%0d got=%b exp=%b", cyc, multi_err, exp_multi);
      end
      compared++;
      if (key_code !== exp_code) begin
        mismatched++;
        $display("FAIL key_code cyc=%0d got=%0d exp=%0d", cyc, key_code, exp_code);
      end
      if (key_valid !== 1'b0 || keypad !== 10'b0) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_stroke cyc=%0d keypad=%b valid=%b exp=none", cyc, keypad, key_valid);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || keypad !== e.kp || key_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL stroke cyc=%0d keypad=%b valid=%b exp_cyc=%0d exp_keypad=%b", cyc, keypad, key_valid, e.cyc, e.kp);
          end
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          compared++;
          mismatched++;
          $display("FAIL missed_stroke cyc=%0d got=%b exp=%b", cyc, keypad, e.kp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int unsigned r, len, a, b;
    logic [9:0] pat;
    rst = 1'b1; keys_raw = '0; lock = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);

    keys_raw = 10'b1 << 7; tick(20); keys_raw = '0; tick(15);

    keys_raw = 10'b1 << 3; tick(2); keys_raw = '0; tick(1);
    keys_raw = 10'b1 << 3; tick(2); keys_raw = '0; tick(1);
    keys_raw = 10'b1 << 3; tick(10); keys_raw = '0; tick(15);

    keys_raw = (10'b1 << 2) | (10'b1 << 5); tick(10);
    keys_raw = 10'b1 << 2; tick(15); keys_raw = '0; tick(10);
    keys_raw = 10'b1 << 2; tick(12); keys_raw = '0; tick(15);

    lock = 1'b1; keys_raw = 10'b1 << 9; tick(12); keys_raw = '0; tick(12);
    lock = 1'b0; keys_raw = 10'b1 << 1; tick(12); keys_raw = '0; tick(15);

    keys_raw = 10'b1 << 4; tick(6);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(12); keys_raw = '0; tick(15);

    keys_raw = 10'b1 << 6; tick(67); keys_raw = '0; tick(15);

    for (int seg = 0; seg < 300; seg++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, 14);
      a   = $urandom_range(0, 9);
      b   = $urandom_range(0, 9);
      if (r < 55)      pat = 10'b1 << a;
      else if (r < 72) pat = '0;
      else if (r < 85) pat = (10'b1 << a) | (10'b1 << b);
      else             pat = 10'b1 << a;
      lock = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end
      if (r >= 85) begin
        for (int k = 0; k < int'(len); k++) begin
          keys_raw = ($urandom_range(0, 1) == 1) ? pat : 10'b0;
          tick(1);
        end
      end else begin
        keys_raw = pat;
        tick(int'(len));
      end
    end

    keys_raw = '0; lock = 1'b0;
    tick(20);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_strokes got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
